// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage. Holds curPC and selects the next fetch
// address from sequential, branch, jump, register-indirect, call and return
// sources. An optional return-address stack (RAS) is built when the macro
// PCSEQ_RAS_EN is defined; otherwise call/return fall back to jump/indirect.
//
// Ports:
//   CLK, Reset          clock, synchronous active-high reset
//   PCWre               PC write enable (0 stalls PC, RAS and flags)
//   PCSrc[2:0]          next-PC source select
//   signedImmediate     sign-extended branch offset in words
//   addr[25:0]          jump target field
//   regAddr             register-indirect target
//   curPC               registered current PC
//   PC4, nextPC         combinational curPC+4 and selected next PC
//   rasEmpty, rasFull   RAS occupancy status
//   rasOvf, rasUnf      sticky overflow / underflow flags
//   pcMisalign          last loaded indirect target had nonzero low bits
module pc_sequencer #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                PCWre,
    input  logic [2:0]          PCSrc,
    input  logic [ADDR_W-1:0]   signedImmediate,
    input  logic [25:0]         addr,
    input  logic [ADDR_W-1:0]   regAddr,
    output logic [ADDR_W-1:0]   curPC,
    output logic [ADDR_W-1:0]   PC4,
    output logic [ADDR_W-1:0]   nextPC,
    output logic                rasEmpty,
    output logic                rasFull,
    output logic                rasOvf,
    output logic                rasUnf,
    output logic                pcMisalign
);

    typedef enum logic [2:0] {
        SRC_SEQ = 3'b000,
        SRC_BEQ = 3'b001,
        SRC_J   = 3'b010,
        SRC_JR  = 3'b011,
        SRC_JAL = 3'b100,
        SRC_RET = 3'b101
    } pc_src_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] pc4_c;
    logic [ADDR_W-1:0] beq_tgt_c;
    logic [ADDR_W-1:0] jump_tgt_c;
    logic [ADDR_W-1:0] ind_tgt_c;
    logic [ADDR_W-1:0] next_pc_c;
    logic              indirect_c;

    assign pc4_c      = pc_q + ADDR_W'(4);
    assign beq_tgt_c  = pc4_c + (signedImmediate << 2);
    assign jump_tgt_c = {pc4_c[ADDR_W-1:28], addr, 2'b00};
    assign ind_tgt_c  = {regAddr[ADDR_W-1:2], 2'b00};

`ifdef PCSEQ_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_c, pop_c, unf_evt_c, ras_we_c;
    logic              empty_c, full_c;
    logic [PTR_W-1:0]  wr_ptr_c;

    assign empty_c  = (cnt_q == '0);
    assign full_c   = (cnt_q == CNT_W'(RAS_DEPTH));
    assign wr_ptr_c = top_q + PTR_W'(1);
`endif

    // Next-PC source selection
    always_comb begin
        next_pc_c  = pc4_c;
        indirect_c = 1'b0;
`ifdef PCSEQ_RAS_EN
        push_c     = 1'b0;
        pop_c      = 1'b0;
        unf_evt_c  = 1'b0;
`endif
        case (PCSrc)
            SRC_BEQ: next_pc_c = beq_tgt_c;
            SRC_J:   next_pc_c = jump_tgt_c;
            SRC_JR: begin
                next_pc_c  = ind_tgt_c;
                indirect_c = 1'b1;
            end
            SRC_JAL: begin
                next_pc_c = jump_tgt_c;
`ifdef PCSEQ_RAS_EN
                push_c    = 1'b1;
`endif
            end
            SRC_RET: begin
`ifdef PCSEQ_RAS_EN
                // Empty stack falls back to the register-indirect target
                if (empty_c) begin
                    next_pc_c  = ind_tgt_c;
                    indirect_c = 1'b1;
                    unf_evt_c  = 1'b1;
                end else begin
                    next_pc_c  = ras_mem[top_q];
                    pop_c      = 1'b1;
                end
`else
                next_pc_c  = ind_tgt_c;
                indirect_c = 1'b1;
`endif
            end
            default: next_pc_c = pc4_c;
        endcase
    end

    // PC and misalign next state; stall holds both
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (PCWre) begin
            pc_d       = next_pc_c;
            misalign_d = indirect_c && (regAddr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PCSEQ_RAS_EN
    // RAS pointer/count/flag next state; full push overwrites the oldest entry
    always_comb begin
        top_d    = top_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ras_we_c = 1'b0;
        if (PCWre) begin
            if (push_c) begin
                ras_we_c = !Reset;
                top_d    = wr_ptr_c;
                if (full_c) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (pop_c) begin
                top_d = top_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (unf_evt_c) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by cnt_q
    always_ff @(posedge CLK) begin
        if (ras_we_c) begin
            ras_mem[wr_ptr_c] <= pc4_c;
        end
    end

    assign rasEmpty = empty_c;
    assign rasFull  = full_c;
    assign rasOvf   = ovf_q;
    assign rasUnf   = unf_q;
`else
    assign rasEmpty = 1'b1;
    assign rasFull  = 1'b0;
    assign rasOvf   = 1'b0;
    assign rasUnf   = 1'b0;
`endif

    assign curPC      = pc_q;
    assign PC4        = pc4_c;
    assign nextPC     = next_pc_c;
    assign pcMisalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (ADDR_W=32, RESET_VEC=0x00400000,
// RAS_DEPTH=4). Expectations adapt to whether PCSEQ_RAS_EN is defined.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 32;

`ifdef PCSEQ_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic              CLK;
    logic              Reset;
    logic              PCWre;
    logic [2:0]        PCSrc;
    logic [ADDR_W-1:0] signedImmediate;
    logic [25:0]       addr;
    logic [ADDR_W-1:0] regAddr;
    logic [ADDR_W-1:0] curPC;
    logic [ADDR_W-1:0] PC4;
    logic [ADDR_W-1:0] nextPC;
    logic              rasEmpty, rasFull, rasOvf, rasUnf, pcMisalign;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_VEC(32'h0040_0000),
        .RAS_DEPTH(4)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .PCWre          (PCWre),
        .PCSrc          (PCSrc),
        .signedImmediate(signedImmediate),
        .addr           (addr),
        .regAddr        (regAddr),
        .curPC          (curPC),
        .PC4            (PC4),
        .nextPC         (nextPC),
        .rasEmpty       (rasEmpty),
        .rasFull        (rasFull),
        .rasOvf         (rasOvf),
        .rasUnf         (rasUnf),
        .pcMisalign     (pcMisalign)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] ret_exp [4];
        ret_exp[0] = 32'h504;
        ret_exp[1] = 32'h404;
        ret_exp[2] = 32'h304;
        ret_exp[3] = 32'h204;

        // Reset overrides PCWre/PCSrc
        Reset = 1'b1; PCWre = 1'b1; PCSrc = 3'b010;
        signedImmediate = '0; addr = 26'h3ff_ffff; regAddr = '0;
        step(); step();
        check("reset_pc",       curPC,      32'h0040_0000);
        check("reset_empty",    32'(rasEmpty), 32'd1);
        check("reset_full",     32'(rasFull),  32'd0);
        check("reset_ovf",      32'(rasOvf),   32'd0);
        check("reset_unf",      32'(rasUnf),   32'd0);
        check("reset_misalign", 32'(pcMisalign), 32'd0);
        check("reset_pc4",      PC4,        32'h0040_0004);

        // Sequential fetch
        Reset = 1'b0; PCSrc = 3'b000;
        step(); check("seq1", curPC, 32'h0040_0004);
        step(); check("seq2", curPC, 32'h0040_0008);
        step(); check("seq3", curPC, 32'h0040_000C);
        step(); check("seq4", curPC, 32'h0040_0010);

        // Backward branch, first stalled then taken
        PCSrc = 3'b001; signedImmediate = 32'hFFFF_FFFD; PCWre = 1'b0;
        #1; check("beq_next", nextPC, 32'h0040_0008);
        step(); check("beq_stall_pc", curPC, 32'h0040_0010);
        check("beq_stall_next", nextPC, 32'h0040_0008);
        PCWre = 1'b1;
        step(); check("beq_taken", curPC, 32'h0040_0008);

        // Reach 0x8000000C via aligned jr, then jump keeps PC4 top bits
        PCSrc = 3'b011; regAddr = 32'h8000_000C;
        step(); check("jr_aligned_pc", curPC, 32'h8000_000C);
        check("jr_aligned_mis", 32'(pcMisalign), 32'd0);
        PCSrc = 3'b010; addr = 26'h000_0100;
        #1; check("j_next", nextPC, 32'h8000_0400);
        step(); check("j_pc", curPC, 32'h8000_0400);

        // Misaligned indirect target, held across a stall, cleared after
        PCSrc = 3'b011; regAddr = 32'h0040_0023;
        step(); check("jr_mis_pc", curPC, 32'h0040_0020);
        check("jr_mis_flag", 32'(pcMisalign), 32'd1);
        PCSrc = 3'b000; PCWre = 1'b0;
        step(); check("mis_stall_hold", 32'(pcMisalign), 32'd1);
        PCWre = 1'b1;
        step(); check("mis_clear", 32'(pcMisalign), 32'd0);
        check("mis_clear_pc", curPC, 32'h0040_0024);

        // Reserved codes act as sequential
        PCSrc = 3'b111;
        #1; check("rsvd_next", nextPC, 32'h0040_0028);

        // Five calls from 0x100..0x500 (jal target 0x1000)
        addr = 26'h000_0400;
        for (int i = 1; i <= 5; i++) begin
            PCSrc = 3'b011; regAddr = 32'(i) << 8;
            step();
            PCSrc = 3'b100;
            step();
            check("jal_target", curPC, 32'h0000_1000);
            if (i == 4) begin
                check("ras_full4", 32'(rasFull), RAS_ON ? 32'd1 : 32'd0);
                check("ras_ovf4",  32'(rasOvf),  32'd0);
            end
        end
        check("ras_full5", 32'(rasFull), RAS_ON ? 32'd1 : 32'd0);
        check("ras_ovf5",  32'(rasOvf),  RAS_ON ? 32'd1 : 32'd0);
        check("ras_empty5", 32'(rasEmpty), RAS_ON ? 32'd0 : 32'd1);

        // Four returns
        PCSrc = 3'b101; regAddr = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            #1; check("ret_next", nextPC, RAS_ON ? ret_exp[i] : 32'h0000_1000);
            step(); check("ret_pc", curPC, RAS_ON ? ret_exp[i] : 32'h0000_1000);
        end
        check("ret_empty", 32'(rasEmpty), 32'd1);
        check("ret_full",  32'(rasFull),  32'd0);
        check("ret_unf0",  32'(rasUnf),   32'd0);

        // Fifth return underflows to regAddr
        #1; check("unf_next", nextPC, 32'h0000_1000);
        step(); check("unf_pc", curPC, 32'h0000_1000);
        check("unf_flag", 32'(rasUnf), RAS_ON ? 32'd1 : 32'd0);
        check("ovf_sticky", 32'(rasOvf), RAS_ON ? 32'd1 : 32'd0);

        // Return with misaligned register target
        regAddr = 32'h0000_2003;
        step(); check("ret_mis_pc", curPC, 32'h0000_2000);
        check("ret_mis_flag", 32'(pcMisalign), 32'd1);

        // Stalled call has no effect on the stack
        PCSrc = 3'b100; PCWre = 1'b0;
        step(); check("stall_push_empty", 32'(rasEmpty), 32'd1);
        check("stall_push_pc", curPC, 32'h0000_2000);
        check("stall_mis_hold", 32'(pcMisalign), 32'd1);

        // Call then reset discards stack and flags
        PCWre = 1'b1;
        step(); check("push1_empty", 32'(rasEmpty), RAS_ON ? 32'd0 : 32'd1);
        check("push1_mis", 32'(pcMisalign), 32'd0);
        Reset = 1'b1; PCWre = 1'b0;
        step(); Reset = 1'b0;
        check("rst2_pc",    curPC,         32'h0040_0000);
        check("rst2_empty", 32'(rasEmpty), 32'd1);
        check("rst2_ovf",   32'(rasOvf),   32'd0);
        check("rst2_unf",   32'(rasUnf),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
